// File: rtl/obj_scan_unit.sv
// Per-frame object scanner: snapshots obj_map, reads each live object's record
// from video memory in index order and forwards it to clipping over valid/ready.
module obj_scan_unit #(
    parameter int unsigned NUM_OBJ = 32,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned DATA_W  = 144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [NUM_OBJ-1:0] obj_map,
    input  logic              changed_in,
    output logic              mem_rd_en,
    output logic [IDX_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_vld,
    output logic [DATA_W-1:0] obj_data,
    output logic [IDX_W-1:0]  obj_idx,
    output logic              obj_vld,
    input  logic              obj_rdy,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [IDX_W:0]    obj_count,
    output logic              changed_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEARCH, S_READ, S_WAIT, S_OUTPUT, S_DONE
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_OBJ-1:0]  map_snap_q, map_snap_d;
    logic                changed_pend_q, changed_pend_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [IDX_W-1:0]    mem_rd_addr_q, mem_rd_addr_d;
    logic [DATA_W-1:0]   obj_data_q, obj_data_d;
    logic [IDX_W-1:0]    obj_idx_q, obj_idx_d;
    logic                obj_vld_q, obj_vld_d;
    logic                scan_busy_q, scan_busy_d;
    logic                scan_done_q, scan_done_d;
    logic [IDX_W:0]      obj_count_q, obj_count_d;
    logic                changed_out_q, changed_out_d;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        map_snap_d     = map_snap_q;
        changed_pend_d = changed_pend_q | changed_in;
        mem_rd_en_d    = 1'b0;
        mem_rd_addr_d  = mem_rd_addr_q;
        obj_data_d     = obj_data_q;
        obj_idx_d      = obj_idx_q;
        obj_vld_d      = obj_vld_q;
        scan_busy_d    = scan_busy_q;
        scan_done_d    = 1'b0;
        obj_count_d    = obj_count_q;
        changed_out_d  = changed_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    map_snap_d     = obj_map;
                    idx_d          = '0;
                    obj_count_d    = '0;
                    scan_busy_d    = 1'b1;
                    changed_out_d  = changed_pend_q | changed_in;
                    changed_pend_d = 1'b0;
                    state_d        = S_SEARCH;
                end
            end
            // Read request is raised on entry to READ so it is a registered output.
            S_SEARCH: begin
                if (map_snap_q[idx_q]) begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = idx_q;
                    state_d       = S_READ;
                end else if (idx_q == LAST_IDX) begin
                    scan_done_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rd_vld) begin
                    obj_data_d = mem_rd_data;
                    obj_idx_d  = idx_q;
                    obj_vld_d  = 1'b1;
                    state_d    = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (obj_vld_q && obj_rdy) begin
                    obj_vld_d   = 1'b0;
                    obj_count_d = obj_count_q + (IDX_W + 1)'(1);
                    if (idx_q == LAST_IDX) begin
                        scan_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SEARCH;
                    end
                end
            end
            S_DONE: begin
                scan_busy_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            map_snap_q     <= '0;
            changed_pend_q <= 1'b0;
            mem_rd_en_q    <= 1'b0;
            mem_rd_addr_q  <= '0;
            obj_data_q     <= '0;
            obj_idx_q      <= '0;
            obj_vld_q      <= 1'b0;
            scan_busy_q    <= 1'b0;
            scan_done_q    <= 1'b0;
            obj_count_q    <= '0;
            changed_out_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            map_snap_q     <= map_snap_d;
            changed_pend_q <= changed_pend_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            obj_data_q     <= obj_data_d;
            obj_idx_q      <= obj_idx_d;
            obj_vld_q      <= obj_vld_d;
            scan_busy_q    <= scan_busy_d;
            scan_done_q    <= scan_done_d;
            obj_count_q    <= obj_count_d;
            changed_out_q  <= changed_out_d;
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign obj_data    = obj_data_q;
    assign obj_idx     = obj_idx_q;
    assign obj_vld     = obj_vld_q;
    assign scan_busy   = scan_busy_q;
    assign scan_done   = scan_done_q;
    assign obj_count   = obj_count_q;
    assign changed_out = changed_out_q;

endmodule

// File: tb/tb_obj_scan_unit.sv
// Bench for obj_scan_unit: table of scan scenarios plus random scans, checked
// against a queue-based model of the scan order, timing and changed flag.
module tb_obj_scan_unit;

    localparam int unsigned NUM_OBJ = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned DATA_W  = 144;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_start;
    logic [NUM_OBJ-1:0] obj_map;
    logic               changed_in;
    logic               mem_rd_en;
    logic [IDX_W-1:0]   mem_rd_addr;
    logic [DATA_W-1:0]  mem_rd_data;
    logic               mem_rd_vld;
    logic [DATA_W-1:0]  obj_data;
    logic [IDX_W-1:0]   obj_idx;
    logic               obj_vld;
    logic               obj_rdy;
    logic               scan_busy;
    logic               scan_done;
    logic [IDX_W:0]     obj_count;
    logic               changed_out;

    obj_scan_unit #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .obj_map(obj_map),
        .changed_in(changed_in), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_vld(mem_rd_vld), .obj_data(obj_data),
        .obj_idx(obj_idx), .obj_vld(obj_vld), .obj_rdy(obj_rdy), .scan_busy(scan_busy),
        .scan_done(scan_done), .obj_count(obj_count), .changed_out(changed_out)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cur = 0;

    // model state
    bit          mbusy, in_done, mpend, mchg, first_pend, rd_out, prev_hold, spurious;
    int unsigned mcount, start_cyc, extra, scan_n, exp_first_rd, done_count;
    int unsigned rq[$];
    int unsigned tq[$];
    logic [31:0] salt;
    int unsigned mem_cnt, mem_lat_cfg, rd_cycle, rd_lat;
    logic [IDX_W-1:0] mem_addr_lat;
    int          stall_cfg, stall_left;
    logic [DATA_W-1:0] prev_data;
    logic [IDX_W-1:0]  prev_idx;

    function automatic logic [DATA_W-1:0] rec(input logic [IDX_W-1:0] a, input logic [31:0] s);
        return {s ^ {{(32-IDX_W){1'b0}}, a}, s + 32'd1, ~s, s ^ 32'h5A5A5A5A, {(16-IDX_W){1'b0}}, a};
    endfunction

    task automatic fail_msg(input string name);
        checks++; errors++;
        $display("FAIL %s at cycle %0d", name, cur);
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cur);
        end
    endtask

    task automatic check_n(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cur);
        end
    endtask

    task automatic check_d(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cur);
        end
    endtask

    task automatic model_reset();
        mbusy = 0; in_done = 0; mpend = 0; mchg = 0; first_pend = 0; rd_out = 0;
        prev_hold = 0; mcount = 0; mem_cnt = 0; stall_left = 0;
        rq.delete(); tq.delete();
    endtask

    // One clock: model consumes this cycle's inputs, then outputs are sampled
    // at the falling edge and the memory/consumer inputs for the next cycle are driven.
    task automatic cyc();
        bit accept;
        accept = frame_start && !mbusy && !in_done;
        in_done = 0;
        if (accept) begin
            mchg = mpend || changed_in;
            mpend = 0;
            mbusy = 1; mcount = 0; start_cyc = cur; extra = 0;
            rq.delete(); tq.delete();
            for (int i = 0; i < NUM_OBJ; i++)
                if (obj_map[i]) begin rq.push_back(i); tq.push_back(i); end
            scan_n = rq.size();
            first_pend = (scan_n > 0);
            if (first_pend) exp_first_rd = cur + 2 + rq[0];
            salt = $urandom;
        end else if (changed_in) begin
            mpend = 1;
        end

        @(negedge clk);
        cur++;
        check_b("scan_busy", scan_busy, mbusy);
        check_b("changed_out", changed_out, mchg);
        check_n("obj_count", int'(obj_count), mcount);

        if (mem_rd_en) begin
            if (rq.size() == 0) fail_msg("unexpected_read");
            else begin
                check_n("rd_addr", int'(mem_rd_addr), rq.pop_front());
                if (first_pend) begin
                    check_n("first_read_cycle", cur, exp_first_rd);
                    first_pend = 0;
                end
            end
        end

        if (prev_hold) begin
            check_b("hold_vld", obj_vld, 1'b1);
            check_d("hold_data", obj_data, prev_data);
            check_n("hold_idx", int'(obj_idx), int'(prev_idx));
        end else if (obj_vld) begin
            if (!rd_out) fail_msg("vld_without_read");
            else check_n("vld_latency", cur, rd_cycle + rd_lat + 1);
            rd_out = 0;
            if (tq.size() == 0) fail_msg("unexpected_obj");
            else begin
                check_n("obj_idx", int'(obj_idx), tq[0]);
                check_d("obj_data", obj_data, rec(IDX_W'(tq[0]), salt));
            end
            stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
        end

        if (obj_vld) begin
            if (stall_left > 0) begin obj_rdy = 1'b0; stall_left--; extra++; end
            else obj_rdy = 1'b1;
        end else begin
            obj_rdy = 1'($urandom_range(0, 1));
        end
        if (obj_vld && obj_rdy) begin
            if (tq.size() > 0) void'(tq.pop_front());
            mcount++;
            prev_hold = 0;
        end else begin
            prev_hold = obj_vld;
            prev_data = obj_data;
            prev_idx  = obj_idx;
        end

        if (scan_done) begin
            if (!mbusy) fail_msg("spurious_scan_done");
            else begin
                check_n("done_count", int'(obj_count), scan_n);
                check_n("done_pending", tq.size() + rq.size(), 0);
                check_n("done_cycle", cur, start_cyc + NUM_OBJ + 1 + 3 * scan_n + extra);
                mbusy = 0; in_done = 1; done_count++;
            end
        end

        mem_rd_vld = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin mem_rd_vld = 1'b1; mem_rd_data = rec(mem_addr_lat, salt); end
        end else if (spurious) begin
            mem_rd_vld  = 1'($urandom_range(0, 1));
            mem_rd_data = rec(IDX_W'($urandom), $urandom);
        end
        if (mem_rd_en) begin
            rd_lat = (mem_lat_cfg == 0) ? $urandom_range(1, 4) : mem_lat_cfg;
            mem_cnt = rd_lat; mem_addr_lat = mem_rd_addr;
            rd_cycle = cur; rd_out = 1; extra += rd_lat - 1;
        end
    endtask

    // chg: 0 none, 1 pulse before frame_start, 2 same cycle as frame_start
    task automatic run_scan(input logic [31:0] map, input int unsigned lat, input int stall,
                            input int unsigned chg, input bit disturb, input bit noise);
        mem_lat_cfg = lat; stall_cfg = stall; obj_map = map;
        changed_in = (chg == 1); cyc();
        frame_start = 1'b1; changed_in = (chg == 2); cyc();
        frame_start = 1'b0; changed_in = 1'b0;
        for (int n = 0; n < 3000 && mbusy; n++) begin
            frame_start = disturb && (n == 10);
            if (frame_start) obj_map = '0;
            changed_in = noise && ($urandom_range(0, 15) == 0);
            cyc();
        end
        frame_start = 1'b0; changed_in = 1'b0;
        if (mbusy) fail_msg("scan_timeout");
        cyc();
    endtask

    typedef struct {
        logic [31:0] map;
        int unsigned lat;
        int          stall;
        int unsigned chg;
        bit          disturb;
        int unsigned exp_cnt;
        bit          exp_chg;
    } vec_t;

    initial begin
        vec_t vt[6];
        int unsigned d0;
        vt[0] = '{32'h0000_0001, 1, 0, 0, 0, 1, 0};
        vt[1] = '{32'h8000_0005, 0, 3, 1, 0, 3, 1};
        vt[2] = '{32'hFFFF_FFFF, 1, 0, 0, 0, 32, 0};
        vt[3] = '{32'h0F00_F00F, 0, -1, 0, 1, 12, 0};
        vt[4] = '{32'h0000_0000, 1, 0, 2, 0, 0, 1};
        vt[5] = '{32'h0001_0200, 0, -1, 0, 0, 2, 0};

        rst_n = 1'b0; frame_start = 1'b0; obj_map = '0; changed_in = 1'b0;
        mem_rd_vld = 1'b0; mem_rd_data = '0; obj_rdy = 1'b0;
        mem_lat_cfg = 1; stall_cfg = 0; spurious = 0; done_count = 0;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;

        // idle with toggling handshake inputs
        spurious = 1;
        repeat (8) cyc();
        spurious = 0;
        cyc();
        check_b("idle_obj_vld", obj_vld, 1'b0);
        check_b("idle_rd_en", mem_rd_en, 1'b0);
        check_b("idle_done", scan_done, 1'b0);
        check_d("idle_data", obj_data, '0);

        foreach (vt[i]) begin
            d0 = done_count;
            run_scan(vt[i].map, vt[i].lat, vt[i].stall, vt[i].chg, vt[i].disturb, 1'b0);
            check_n("tbl_count", int'(obj_count), vt[i].exp_cnt);
            check_b("tbl_changed", changed_out, vt[i].exp_chg);
            check_n("tbl_done_pulses", done_count - d0, 1);
        end

        for (int r = 0; r < 6; r++)
            run_scan($urandom, 0, -1, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1);

        // reset while an object is waiting in OUTPUT
        run_scan(32'h0, 1, 0, 1, 0, 0);
        mem_lat_cfg = 1; stall_cfg = 1000; obj_map = 32'h0000_0008;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        for (int n = 0; n < 100 && !obj_vld; n++) cyc();
        check_b("pre_reset_vld", obj_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_b("rst_obj_vld", obj_vld, 1'b0);
        check_b("rst_busy", scan_busy, 1'b0);
        check_b("rst_changed", changed_out, 1'b0);
        check_n("rst_count", int'(obj_count), 0);
        check_n("rst_idx", int'(obj_idx), 0);
        check_d("rst_data", obj_data, '0);
        model_reset();
        mem_rd_vld = 1'b0;
        stall_cfg = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        d0 = done_count;
        run_scan(32'h0000_0001, 1, 0, 0, 0, 0);
        check_n("post_reset_count", int'(obj_count), 1);
        check_n("post_reset_done", done_count - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout at cycle %0d", cur);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/obj_scan_unit.md
Name: obj_scan_unit

Overview:
Downstream consumer of the object unit's obj_map and the video-memory object store. Once per frame it snapshots the live-object bitmap and walks it from index 0 upward. For each live object it issues one read of that object's 144-bit record from video memory. It then forwards the record, with its index, to the clipping logic over a valid/ready handshake. It also carries the frame's "scene changed" flag to the framebuffer and rasterizer.

Parameters:
NUM_OBJ, 32, number of object slots (bits of obj_map)
IDX_W, 5, object index width (log2 NUM_OBJ)
DATA_W, 144, width of one object record in video memory

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
frame_start  in  1  pulse; begin a scan of the current obj_map
obj_map  in  NUM_OBJ  live-object bitmap; bit i set = slot i holds an object
changed_in  in  1  pulse; object set or transforms modified since last frame
mem_rd_en  out  1  one-cycle video-memory read request
mem_rd_addr  out  IDX_W  object slot to read, valid while mem_rd_en=1
mem_rd_data  in  DATA_W  read data
mem_rd_vld  in  1  read data valid, any latency >=1 after mem_rd_en
obj_data  out  DATA_W  object record to clipping
obj_idx  out  IDX_W  slot index of obj_data
obj_vld  out  1  obj_data/obj_idx valid
obj_rdy  in  1  clipping accepts the transfer
scan_busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse at scan end
obj_count  out  IDX_W+1  objects forwarded in the current or last scan
changed_out  out  1  frame's changed flag, held for the whole scan

Behaviour:
- All outputs are registered. Reset value of every output is 0; internal state is IDLE, idx=0, map_snap=0, changed_pend=0.
- changed_pend is set by changed_in in any cycle. At accepted frame_start it is copied into changed_out and cleared. If changed_in and frame_start occur in the same cycle, changed_out=1 and changed_pend ends at 0. changed_out holds until the next accepted frame_start.
- IDLE: frame_start -> map_snap<=obj_map, idx<=0, obj_count<=0, scan_busy<=1, go to SEARCH. frame_start in any other state is ignored.
- SEARCH: examines one index per cycle.
  - map_snap[idx]=1 -> go to READ.
  - Else if idx==NUM_OBJ-1 -> go to DONE.
  - Else idx<=idx+1.
- READ: mem_rd_en=1 and mem_rd_addr=idx for exactly one cycle -> go to WAIT.
- WAIT: on mem_rd_vld, obj_data<=mem_rd_data, obj_idx<=idx, obj_vld<=1 -> go to OUTPUT. mem_rd_vld is ignored in every state other than WAIT.
- OUTPUT: obj_vld, obj_data and obj_idx are held stable until obj_rdy=1. On transfer (obj_vld && obj_rdy):
  - obj_vld<=0, obj_count<=obj_count+1.
  - If idx==NUM_OBJ-1 -> go to DONE; else idx<=idx+1 and go to SEARCH.
  - obj_rdy while obj_vld=0 has no effect.
- DONE: scan_done=1 for one cycle, scan_busy<=0 -> go to IDLE. obj_count holds its final value until the next accepted frame_start.
- Timing: a frame_start accepted in cycle 0 with obj_map bit 0 set gives:
  - SEARCH in cycle 1, mem_rd_en high in cycle 2.
  - With mem_rd_vld in cycle 3, obj_vld goes high in cycle 4.
- Scan length with no stalls: NUM_OBJ SEARCH cycles plus 3 cycles per live object (READ, WAIT with 1-cycle latency, OUTPUT with obj_rdy=1), plus 1 DONE cycle.
- Empty map: 32 SEARCH cycles, then scan_done, obj_count=0. No mem_rd_en or obj_vld is generated.
- Full map: 32 objects forwarded, obj_count=32. idx never wraps; the scan ends after index 31.
- Snapshot isolation: changes to obj_map during a scan (create, delete or delete-all in the object unit) do not affect the current scan.
- Reset mid-scan: all registers return to reset values asynchronously and any pending transfer is dropped.

Test Plan:
- Reset then idle: all outputs 0; obj_rdy and mem_rd_vld toggling -> no change.
- obj_map=0x0000_0001, frame_start in cycle 0, memory latency 1, obj_rdy=1:
  - mem_rd_en/addr=0 in cycle 2, obj_vld with obj_idx=0 in cycle 4.
  - scan_done after the 31 remaining SEARCH cycles, obj_count=1.
- obj_map=0x8000_0005, random memory latency 1–4, obj_rdy low for 3 cycles on each object:
  - records forwarded in order 0, 2, 31; data held stable during stalls; obj_count=3.
- obj_map=0xFFFF_FFFF, obj_rdy=1: 32 transfers with idx 0..31, obj_count=32, exactly one scan_done.
- Mid-scan obj_map changed to 0 and a second frame_start applied: current scan still forwards all snapshot objects; the second frame_start is ignored.
- changed_in pulse, then frame_start: changed_out=1 for that whole scan. Next frame_start with no changed_in -> changed_out=0. rst_n asserted mid-OUTPUT -> obj_vld=0 and state returns to IDLE immediately.
